// File: rtl/sevenseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_driver
//
// Time-multiplexed multi-digit BCD seven-segment driver. A shadow buffer holds
// NUM_DIGITS BCD codes plus per-digit decimal points. The digits are scanned
// one at a time onto a shared segment bus. Each digit slot lasts REFRESH_DIV
// clocks. The first clock of every slot is a blank guard cycle so that the old
// segment pattern never ghosts onto the next anode. Optional leading-zero
// blanking is supported, and codes above 9 are shown as a dash and flagged on
// err.
//
// Ports:
//   clk        system clock, rising-edge active
//   reset      asynchronous, active-high reset
//   digits_in  BCD codes, digit k = digits_in[4k+3:4k], digit 0 least significant
//   load       captures digits_in / dp_in into the shadow buffer on a clk edge
//   blank_lz   enables leading-zero blanking (sampled every cycle)
//   dp_in      decimal point request per digit, active-high
//   Seg        segments a..g (Seg[0] = a), active-low, registered
//   dp         decimal point, active-low, registered
//   an         digit enables, active-low, registered
//   err        high while the displayed digit holds a code > 9, registered
// -----------------------------------------------------------------------------
module sevenseg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int IDX_W       = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [0:6]              Seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    err
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] shadow_digits;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic                    blank_q;

    logic [3:0]              cur_digit;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    all_zero;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic [0:6]              seg_next;
    logic                    dp_next;
    logic [NUM_DIGITS-1:0]   an_next;
    logic                    err_next;

    // BCD to active-low a..g; anything above 9 renders as a dash (g only).
    function automatic logic [0:6] decode_bcd(input logic [3:0] code);
        logic [0:6] pattern;
        case (code)
            4'd0:    pattern = 7'b0000001;
            4'd1:    pattern = 7'b1001111;
            4'd2:    pattern = 7'b0010010;
            4'd3:    pattern = 7'b0000110;
            4'd4:    pattern = 7'b1001100;
            4'd5:    pattern = 7'b0100100;
            4'd6:    pattern = 7'b0100000;
            4'd7:    pattern = 7'b0001111;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0000100;
            default: pattern = 7'b1111110;
        endcase
        return pattern;
    endfunction

    // Select the digit under the scan index and decide whether it is blanked.
    // Walking from the most significant digit down, all_zero stays true only
    // while every digit at or above k is zero. Any nonzero code, including an
    // invalid one, therefore ends blanking for itself and all digits below.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves a value held, which would infer a latch.
        cur_digit = 4'd0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        all_zero  = 1'b1;
        an_sel    = '1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            all_zero = all_zero && (shadow_digits[4*k +: 4] == 4'd0);
            if (idx == IDX_W'(k)) begin
                cur_digit = shadow_digits[4*k +: 4];
                cur_dp    = shadow_dp[k];
                cur_blank = (k > 0) && blank_q && all_zero;
                an_sel[k] = 1'b0;
            end
        end

        // cnt == 0 is the guard cycle: everything dark.
        lit      = (cnt != '0) && !cur_blank;
        seg_next = lit ? decode_bcd(cur_digit) : 7'b1111111;
        dp_next  = lit ? ~cur_dp : 1'b1;
        an_next  = lit ? an_sel : '1;
        err_next = lit && (cur_digit > 4'd9);
    end

    // NOTE: all state, including the shadow buffer, is updated with
    // non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt           <= '0;
            idx           <= '0;
            // NOTE: the shadow buffer is explicitly cleared on reset, so a
            // display restarted after reset shows zeros until the next load.
            shadow_digits <= '0;
            shadow_dp     <= '0;
            blank_q       <= 1'b0;
            Seg           <= 7'b1111111;
            dp            <= 1'b1;
            an            <= '1;
            err           <= 1'b0;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (load) begin
                shadow_digits <= digits_in;
                shadow_dp     <= dp_in;
            end
            blank_q <= blank_lz;

            Seg <= seg_next;
            dp  <= dp_next;
            an  <= an_next;
            err <= err_next;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_scan_driver
//
// Self-checking bench for sevenseg_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4.
// A reference model tracks the number of clock edges since reset. It derives
// the slot position and digit from plain arithmetic on that count, and it keeps
// the loaded digits in an array. Each output is predicted from the model state
// as it stood before the edge that produced that output.
// -----------------------------------------------------------------------------
module tb_sevenseg_scan_driver;

    localparam int ND = 4;
    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  dp_in;
    logic [0:6]  Seg;
    logic        dp;
    logic [3:0]  an;
    logic        err;

    always #5 clk = ~clk;

    sevenseg_scan_driver #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD),
        .IDX_W      (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .digits_in(digits_in),
        .load     (load),
        .blank_lz (blank_lz),
        .dp_in    (dp_in),
        .Seg      (Seg),
        .dp       (dp),
        .an       (an),
        .err      (err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int         m_pos;
    logic [3:0] m_dig [ND];
    logic [3:0] m_dp;
    logic       m_blank;
    logic [0:6] seg_tab [10];

    logic [0:6] exp_seg;
    logic       exp_dp;
    logic [3:0] exp_an;
    logic       exp_err;

    task automatic model_reset();
        m_pos   = 0;
        for (int k = 0; k < ND; k++) m_dig[k] = 4'd0;
        m_dp    = 4'd0;
        m_blank = 1'b0;
        exp_seg = 7'b1111111;
        exp_dp  = 1'b1;
        exp_an  = 4'b1111;
        exp_err = 1'b0;
    endtask

    function automatic bit model_blanked(input int d);
        bit z;
        z = 1'b1;
        for (int j = d; j < ND; j++) if (m_dig[j] != 4'd0) z = 1'b0;
        return m_blank && (d > 0) && z;
    endfunction

    // Called right after each rising edge: predicts the output that edge
    // produced, then absorbs the inputs that edge sampled.
    task automatic model_edge();
        int slot_pos;
        int d;
        if (reset) begin
            model_reset();
            return;
        end
        slot_pos = m_pos % RD;
        d        = (m_pos / RD) % ND;
        exp_seg  = 7'b1111111;
        exp_dp   = 1'b1;
        exp_an   = 4'b1111;
        exp_err  = 1'b0;
        if (slot_pos != 0 && !model_blanked(d)) begin
            exp_an[d] = 1'b0;
            if (m_dig[d] <= 4'd9) begin
                exp_seg = seg_tab[m_dig[d]];
            end else begin
                exp_seg = 7'b1111110;
                exp_err = 1'b1;
            end
            exp_dp = ~m_dp[d];
        end
        m_pos++;
        if (load) begin
            for (int k = 0; k < ND; k++) m_dig[k] = digits_in[4*k +: 4];
            m_dp = dp_in;
        end
        m_blank = blank_lz;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({Seg, dp, an, err} !== {7'b1111111, 1'b1, 4'b1111, 1'b0}) begin
            errors++;
            $display("FAIL reset_async: got Seg=%b dp=%b an=%b err=%b, expected Seg=1111111 dp=1 an=1111 err=0",
                     Seg, dp, an, err);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({Seg, dp, an, err} !== {exp_seg, exp_dp, exp_an, exp_err}) begin
                errors++;
                $display("FAIL reset_hold: got Seg=%b dp=%b an=%b err=%b, expected Seg=%b dp=%b an=%b err=%b",
                         Seg, dp, an, err, exp_seg, exp_dp, exp_an, exp_err);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if ({Seg, dp, an, err} !== {exp_seg, exp_dp, exp_an, exp_err}) begin
                errors++;
                $display("FAIL reset_scan cyc %0d: got Seg=%b dp=%b an=%b err=%b, expected Seg=%b dp=%b an=%b err=%b",
                         i, Seg, dp, an, err, exp_seg, exp_dp, exp_an, exp_err);
            end
            if (i == 1) begin
                checks++;
                if ({Seg, an} !== {7'b0000001, 4'b1110}) begin
                    errors++;
                    $display("FAIL reset_first_digit: got Seg=%b an=%b, expected Seg=0000001 an=1110", Seg, an);
                end
            end
        end
    endtask

    task automatic test_scan_1234();
        digits_in = 16'h1234;
        dp_in     = 4'b0010;
        load      = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 24; i++) begin
            // Unloaded input wiggle must not reach the display.
            digits_in = 16'($urandom);
            dp_in     = 4'($urandom);
            tick();
            checks++;
            if ({Seg, dp, an, err} !== {exp_seg, exp_dp, exp_an, exp_err}) begin
                errors++;
                $display("FAIL scan_1234 cyc %0d: got Seg=%b dp=%b an=%b err=%b, expected Seg=%b dp=%b an=%b err=%b",
                         i, Seg, dp, an, err, exp_seg, exp_dp, exp_an, exp_err);
            end
        end
    endtask

    task automatic test_blanking();
        logic [15:0] pats [2];
        int lit_hi;
        pats[0]  = 16'h0050;
        pats[1]  = 16'h0000;
        blank_lz = 1'b1;
        for (int p = 0; p < 2; p++) begin
            digits_in = pats[p];
            dp_in     = 4'b1111;
            load      = 1'b1;
            tick();
            load   = 1'b0;
            lit_hi = 0;
            for (int i = 0; i < 17; i++) begin
                tick();
                if (i > 0 && (an[3] == 1'b0 || an[2] == 1'b0)) lit_hi++;
                checks++;
                if ({Seg, dp, an, err} !== {exp_seg, exp_dp, exp_an, exp_err}) begin
                    errors++;
                    $display("FAIL blank_lz pat %h cyc %0d: got Seg=%b dp=%b an=%b err=%b, expected Seg=%b dp=%b an=%b err=%b",
                             pats[p], i, Seg, dp, an, err, exp_seg, exp_dp, exp_an, exp_err);
                end
            end
            checks++;
            if (lit_hi != 0) begin
                errors++;
                $display("FAIL blank_lz_upper pat %h: got %0d lit cycles on digits 3/2, expected 0", pats[p], lit_hi);
            end
        end
        blank_lz = 1'b0;
        dp_in    = 4'b0000;
    endtask

    task automatic test_invalid();
        int err_cnt;
        int d2_cnt;
        int d3_cnt;
        blank_lz  = 1'b0;
        digits_in = 16'h0A07;
        dp_in     = 4'b0000;
        load      = 1'b1;
        tick();
        load    = 1'b0;
        err_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (err === 1'b1) err_cnt++;
            checks++;
            if ({Seg, dp, an, err} !== {exp_seg, exp_dp, exp_an, exp_err}) begin
                errors++;
                $display("FAIL invalid cyc %0d: got Seg=%b dp=%b an=%b err=%b, expected Seg=%b dp=%b an=%b err=%b",
                         i, Seg, dp, an, err, exp_seg, exp_dp, exp_an, exp_err);
            end
        end
        checks++;
        if (err_cnt != 3) begin
            errors++;
            $display("FAIL invalid_err_count: got %0d err cycles, expected 3", err_cnt);
        end

        blank_lz = 1'b1;
        tick();
        d2_cnt = 0;
        d3_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (an[2] == 1'b0) d2_cnt++;
            if (an[3] == 1'b0) d3_cnt++;
            checks++;
            if ({Seg, dp, an, err} !== {exp_seg, exp_dp, exp_an, exp_err}) begin
                errors++;
                $display("FAIL invalid_blank cyc %0d: got Seg=%b dp=%b an=%b err=%b, expected Seg=%b dp=%b an=%b err=%b",
                         i, Seg, dp, an, err, exp_seg, exp_dp, exp_an, exp_err);
            end
        end
        checks++;
        if (d2_cnt != 3 || d3_cnt != 0) begin
            errors++;
            $display("FAIL invalid_blank_slots: got digit2 lit %0d digit3 lit %0d, expected 3 and 0", d2_cnt, d3_cnt);
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_midslot_load();
        logic [3:0] an_before;
        digits_in = 16'h1111;
        load      = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < RD && (m_pos % RD) != 2; i++) begin
            tick();
            checks++;
            if ({Seg, dp, an, err} !== {exp_seg, exp_dp, exp_an, exp_err}) begin
                errors++;
                $display("FAIL midslot_align cyc %0d: got Seg=%b an=%b, expected Seg=%b an=%b",
                         i, Seg, an, exp_seg, exp_an);
            end
        end
        digits_in = 16'h9999;
        load      = 1'b1;
        tick();
        load      = 1'b0;
        an_before = an;
        checks++;
        if (Seg !== 7'b1001111) begin
            errors++;
            $display("FAIL midslot_old: got Seg=%b, expected Seg=1001111", Seg);
        end
        tick();
        checks++;
        if (Seg !== 7'b0000100 || an !== an_before) begin
            errors++;
            $display("FAIL midslot_new: got Seg=%b an=%b, expected Seg=0000100 an=%b", Seg, an, an_before);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if ({Seg, dp, an, err} !== {exp_seg, exp_dp, exp_an, exp_err}) begin
                errors++;
                $display("FAIL midslot_after cyc %0d: got Seg=%b dp=%b an=%b err=%b, expected Seg=%b dp=%b an=%b err=%b",
                         i, Seg, dp, an, err, exp_seg, exp_dp, exp_an, exp_err);
            end
        end
    endtask

    task automatic test_reset_midscan();
        // Reach the state idx=2, cnt=3.
        for (int i = 0; i < RD * ND && (m_pos % (RD * ND)) != 11; i++) tick();
        #2 reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({Seg, dp, an, err} !== {7'b1111111, 1'b1, 4'b1111, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_async: got Seg=%b dp=%b an=%b err=%b, expected Seg=1111111 dp=1 an=1111 err=0",
                     Seg, dp, an, err);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if ({Seg, dp, an, err} !== {exp_seg, exp_dp, exp_an, exp_err}) begin
                errors++;
                $display("FAIL reset_mid_scan cyc %0d: got Seg=%b dp=%b an=%b err=%b, expected Seg=%b dp=%b an=%b err=%b",
                         i, Seg, dp, an, err, exp_seg, exp_dp, exp_an, exp_err);
            end
            if (i == 1) begin
                checks++;
                if ({Seg, an} !== {7'b0000001, 4'b1110}) begin
                    errors++;
                    $display("FAIL reset_mid_first: got Seg=%b an=%b, expected Seg=0000001 an=1110", Seg, an);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            load = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < ND; k++)
                digits_in[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            dp_in = 4'($urandom);
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            tick();
            checks++;
            if ({Seg, dp, an, err} !== {exp_seg, exp_dp, exp_an, exp_err}) begin
                errors++;
                $display("FAIL random cyc %0d: got Seg=%b dp=%b an=%b err=%b, expected Seg=%b dp=%b an=%b err=%b",
                         i, Seg, dp, an, err, exp_seg, exp_dp, exp_an, exp_err);
            end
        end
        load = 1'b0;
    endtask

    initial begin
        seg_tab[0] = 7'b0000001;
        seg_tab[1] = 7'b1001111;
        seg_tab[2] = 7'b0010010;
        seg_tab[3] = 7'b0000110;
        seg_tab[4] = 7'b1001100;
        seg_tab[5] = 7'b0100100;
        seg_tab[6] = 7'b0100000;
        seg_tab[7] = 7'b0001111;
        seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0000100;

        reset     = 1'b0;
        load      = 1'b0;
        blank_lz  = 1'b0;
        digits_in = 16'h0000;
        dp_in     = 4'b0000;
        model_reset();

        test_reset();
        test_scan_1234();
        test_blanking();
        test_invalid();
        test_midslot_load();
        test_reset_midscan();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
